intr_source_ctrl: RTL and testbench
===================================

Name: intr_source_ctrl

Overview:
Interrupt request controller on the device side of the single-cycle CPU's intr/inta handshake. It collects edge-triggered requests from NSRC peripheral lines, applies a mask, and drives the CPU's intr input. On inta it resolves the winning source by fixed priority, clears its pending bit, and reports the source id to software. It sits between the peripherals and the sc_interrupt core at top level, replacing the bench-driven intr pulse.

Parameters:
NSRC, 4, number of interrupt source lines (2..16).
IDW, 2, width of source id; must satisfy 2**IDW >= NSRC.

Ports:
clk  input  1  system clock; all state updates on rising edge.
clr  input  1  asynchronous, active-high reset.
irq  input  NSRC  peripheral request lines, synchronous to clk; a 0->1 transition is one request.
mask_we  input  1  mask register write strobe.
mask_wdata  input  NSRC  new mask value; bit i = 1 enables source i.
intr  output  1  interrupt request to the CPU.
inta  input  1  interrupt acknowledge from the CPU.
ack_id  output  IDW  id of the last acknowledged source.
ack_valid  output  1  one-cycle pulse marking ack_id as newly updated.
pending  output  NSRC  raw pending register, readable by software.
ack_cnt  output  8  count of acknowledged interrupts.

Behaviour:
- Reset (clr=1, asynchronous): intr=0, ack_id=0, ack_valid=0, pending=0, ack_cnt=0, mask=all ones, irq_d=0, state=IDLE. Reset asserted mid-handshake aborts the handshake; outstanding requests are lost.
- Edge detect: irq_d <= irq each cycle. set_i = irq[i] & ~irq_d[i]. pending[i] <= set_i | (pending[i] & ~clr_i).
- Set/clear collision: if the same bit is set and cleared in one cycle, set wins and the new edge is kept.
- Active set: act = pending & mask. The winner is the lowest index i with act[i]=1; index 0 has highest priority.
- Mask: mask <= mask_wdata on mask_we. Masking never clears pending. A mask write and inta in the same cycle: arbitration uses the pre-write mask.
- FSM, intr is a registered output:
  IDLE: intr=0. If act != 0, go to REQ.
  REQ: intr=1.
    If inta=1: latch ack_id = winner, clear pending[winner], pulse ack_valid on the next cycle, increment ack_cnt (wraps 255->0), go to ACKD.
    Else if act = 0 (all pending masked off): withdraw, go to IDLE.
  ACKD: intr=0. Stay until inta=0, then go to IDLE. Requests that arrive meanwhile are held in pending.
- Latency:
  irq rising, sampled at edge k: pending set after edge k; intr=1 after edge k+1.
  inta sampled at edge m: intr=0, ack_id/ack_valid/ack_cnt updated after edge m.
  Minimum gap between consecutive intr pulses: 2 cycles (ACKD, then IDLE).
- inta while in IDLE or ACKD is ignored (no clear, no count).
- Level irq held high produces exactly one request per rising edge.

Test Plan:
- Reset then single request: clr pulse 20 ns; irq[2] 0->1 held high -> pending=4'b0100 one cycle later; intr=1 the following cycle; inta=1 for one cycle -> intr=0, ack_id=2, ack_valid pulses for 1 cycle, pending=0, ack_cnt=1; no further intr while irq[2] stays high.
- Priority: irq[3] and irq[1] rise in the same cycle -> first ack gives ack_id=1 with pending=4'b1000 remaining; after inta drops, intr reasserts; second ack gives ack_id=3; ack_cnt=2.
- Masking and withdrawal: mask=4'b1110, irq[0] rises -> pending=4'b0001, intr stays 0. Write mask=4'b1111 -> intr=1. Write mask=4'b1110 before any inta -> intr drops to 0 and pending still 4'b0001.
- Collision: irq[1] gets a new rising edge in the same cycle inta acknowledges source 1 -> pending[1] stays 1; intr reasserts after ACKD->IDLE.
- Long inta and stray inta: inta held high 3 cycles -> one ack only, ack_cnt increments once. inta pulse in IDLE -> no state change.
- Reset mid-handshake and counter wrap: clr asserted while in REQ -> intr=0 and pending=0 immediately, without waiting for a clock edge. 256 acks -> ack_cnt returns to 0.

Source files
------------

// File: rtl/intr_source_ctrl.sv
// Device-side interrupt controller: edge-detects peripheral requests, masks them,
// and runs the intr/inta handshake with fixed priority (source 0 highest).
module intr_source_ctrl #(
  parameter int NSRC = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [NSRC-1:0] irq,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  output logic            intr,
  input  logic            inta,
  output logic [IDW-1:0]  ack_id,
  output logic            ack_valid,
  output logic [NSRC-1:0] pending,
  output logic [7:0]      ack_cnt
);

  // state | meaning
  // IDLE  | no request presented to the CPU
  // REQ   | intr asserted, waiting for inta
  // ACKD  | acknowledged, waiting for inta to drop
  typedef enum logic [1:0] {IDLE, REQ, ACKD} state_t;

  state_t          state, state_nxt;
  logic [NSRC-1:0] irq_d;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] act;
  logic [NSRC-1:0] set_vec;
  logic [NSRC-1:0] pend_clr;
  logic [IDW-1:0]  winner;
  logic            ack_fire;

  assign act     = pending & mask;
  assign set_vec = irq & ~irq_d;
  assign intr    = (state == REQ);

  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (act[i]) winner = IDW'(i);
    end
  end

  // An inta that finds every pending source masked off has nothing to resolve,
  // so it is treated as a withdrawal rather than an acknowledge.
  always_comb begin
    state_nxt = state;
    ack_fire  = 1'b0;
    pend_clr  = '0;
    case (state)
      IDLE: if (act != '0) state_nxt = REQ;
      REQ: begin
        if (inta && act != '0) begin
          ack_fire         = 1'b1;
          pend_clr[winner] = 1'b1;
          state_nxt        = ACKD;
        end else if (act == '0) begin
          state_nxt = IDLE;
        end
      end
      ACKD: if (!inta) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      irq_d     <= '0;
      mask      <= '1;
      pending   <= '0;
      ack_id    <= '0;
      ack_valid <= 1'b0;
      ack_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      irq_d     <= irq;
      // a fresh edge on the bit being acknowledged survives the clear
      pending   <= set_vec | (pending & ~pend_clr);
      ack_valid <= ack_fire;
      if (mask_we) mask <= mask_wdata;
      if (ack_fire) begin
        ack_id  <= winner;
        ack_cnt <= ack_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_intr_source_ctrl.sv
// Directed bench for intr_source_ctrl: a per-cycle reference model checked on
// every falling edge, plus literal expectations at key points of each scenario.
module tb_intr_source_ctrl;

  localparam int NSRC = 4;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            clr = 1'b1;
  logic [NSRC-1:0] irq = '0;
  logic            mask_we = 1'b0;
  logic [NSRC-1:0] mask_wdata = '0;
  logic            intr;
  logic            inta = 1'b0;
  logic [IDW-1:0]  ack_id;
  logic            ack_valid;
  logic [NSRC-1:0] pending;
  logic [7:0]      ack_cnt;

  int total = 0;
  int bad   = 0;

  intr_source_ctrl #(.NSRC(NSRC), .IDW(IDW)) dut (
    .clk(clk), .clr(clr), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .intr(intr), .inta(inta), .ack_id(ack_id), .ack_valid(ack_valid),
    .pending(pending), .ack_cnt(ack_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: requests are rising edges, the CPU sees a request while
  // any unmasked source is pending and no acknowledge is being held.
  logic [NSRC-1:0] m_pend, m_mask, m_prev;
  logic            m_intr, m_hold, m_valid;
  logic [IDW-1:0]  m_id;
  logic [7:0]      m_cnt;

  always @(posedge clk or posedge clr) begin
    logic [NSRC-1:0] act, clrv;
    int              win;
    logic            n_intr, n_hold, n_valid;
    logic [IDW-1:0]  n_id;
    logic [7:0]      n_cnt;
    if (clr) begin
      m_pend <= '0; m_mask <= '1; m_prev <= '0; m_intr <= 1'b0;
      m_hold <= 1'b0; m_valid <= 1'b0; m_id <= '0; m_cnt <= '0;
    end else begin
      act = m_pend & m_mask;
      win = 0;
      while (win < NSRC && !act[win]) win++;
      clrv = '0; n_intr = m_intr; n_hold = m_hold; n_valid = 1'b0;
      n_id = m_id; n_cnt = m_cnt;
      if (m_intr) begin
        if (inta && act != '0) begin
          clrv = NSRC'(1) << win;
          n_id = IDW'(win);
          n_valid = 1'b1;
          n_cnt = m_cnt + 8'd1;
          n_intr = 1'b0;
          n_hold = 1'b1;
        end else if (act == '0) begin
          n_intr = 1'b0;
        end
      end else if (m_hold) begin
        if (!inta) n_hold = 1'b0;
      end else if (act != '0) begin
        n_intr = 1'b1;
      end
      m_pend  <= (irq & ~m_prev) | (m_pend & ~clrv);
      m_mask  <= mask_we ? mask_wdata : m_mask;
      m_prev  <= irq;
      m_intr  <= n_intr;
      m_hold  <= n_hold;
      m_valid <= n_valid;
      m_id    <= n_id;
      m_cnt   <= n_cnt;
    end
  end

  always @(negedge clk) begin
    total += 5;
    if (intr !== m_intr) begin
      bad++; $display("FAIL model_intr got=%0b want=%0b t=%0t", intr, m_intr, $time);
    end
    if (ack_id !== m_id) begin
      bad++; $display("FAIL model_ack_id got=%0d want=%0d t=%0t", ack_id, m_id, $time);
    end
    if (ack_valid !== m_valid) begin
      bad++; $display("FAIL model_ack_valid got=%0b want=%0b t=%0t", ack_valid, m_valid, $time);
    end
    if (pending !== m_pend) begin
      bad++; $display("FAIL model_pending got=%b want=%b t=%0t", pending, m_pend, $time);
    end
    if (ack_cnt !== m_cnt) begin
      bad++; $display("FAIL model_ack_cnt got=%0d want=%0d t=%0t", ack_cnt, m_cnt, $time);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_mask(input logic [NSRC-1:0] v);
    mask_we = 1'b1; mask_wdata = v;
    step();
    mask_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #20 clr = 1'b0;
    step();
    chk("reset_intr", 32'(intr), 0);
    chk("reset_pending", 32'(pending), 0);
    chk("reset_cnt", 32'(ack_cnt), 0);
    chk("reset_id", 32'(ack_id), 0);

    // single request on source 2
    irq = 4'b0100;
    step(); chk("s1_pending", 32'(pending), 32'h4); chk("s1_intr_early", 32'(intr), 0);
    step(); chk("s1_intr", 32'(intr), 1);
    inta = 1'b1;
    step();
    chk("s1_intr_drop", 32'(intr), 0); chk("s1_id", 32'(ack_id), 2);
    chk("s1_valid", 32'(ack_valid), 1); chk("s1_pend_clr", 32'(pending), 0);
    chk("s1_cnt", 32'(ack_cnt), 1);
    inta = 1'b0;
    step(); chk("s1_valid_pulse", 32'(ack_valid), 0);
    step(4); chk("s1_level_no_rerequest", 32'(intr), 0);
    irq = '0; step();

    // simultaneous sources 3 and 1
    irq = 4'b1010;
    step(); chk("s2_pending", 32'(pending), 32'hA);
    step(); chk("s2_intr", 32'(intr), 1);
    inta = 1'b1;
    step(); chk("s2_id1", 32'(ack_id), 1); chk("s2_pend_left", 32'(pending), 32'h8);
    inta = 1'b0;
    step(); chk("s2_gap", 32'(intr), 0);
    step(); chk("s2_reassert", 32'(intr), 1);
    inta = 1'b1;
    step(); chk("s2_id3", 32'(ack_id), 3); chk("s2_cnt", 32'(ack_cnt), 3);
    inta = 1'b0; step(); irq = '0; step();

    // masking and withdrawal
    wr_mask(4'b1110);
    irq = 4'b0001;
    step(); chk("s3_pending", 32'(pending), 32'h1);
    step(2); chk("s3_masked", 32'(intr), 0);
    wr_mask(4'b1111);
    step(); chk("s3_unmasked", 32'(intr), 1);
    wr_mask(4'b1110);
    step(); chk("s3_withdraw", 32'(intr), 0); chk("s3_pend_kept", 32'(pending), 32'h1);
    wr_mask(4'b1111);
    step(); chk("s3_again", 32'(intr), 1);
    inta = 1'b1;
    step(); chk("s3_id", 32'(ack_id), 0); chk("s3_cnt", 32'(ack_cnt), 4);
    inta = 1'b0; irq = '0; step();

    // set/clear collision on source 1
    irq = 4'b0010;
    step(2); chk("s4_intr", 32'(intr), 1);
    irq = '0; step();
    irq = 4'b0010; inta = 1'b1;
    step(); chk("s4_id", 32'(ack_id), 1); chk("s4_pend_kept", 32'(pending), 32'h2);
    chk("s4_cnt", 32'(ack_cnt), 5);
    inta = 1'b0;
    step(); chk("s4_gap", 32'(intr), 0);
    step(); chk("s4_reassert", 32'(intr), 1);

    // long inta: one acknowledge only
    inta = 1'b1;
    step(3); chk("s5_long_cnt", 32'(ack_cnt), 6); chk("s5_long_intr", 32'(intr), 0);
    inta = 1'b0; step(); irq = '0; step();
    inta = 1'b1; step(); inta = 1'b0; step();
    chk("s5_stray_cnt", 32'(ack_cnt), 6); chk("s5_stray_intr", 32'(intr), 0);

    // asynchronous reset in the middle of a request
    irq = 4'b0100;
    step(2); chk("s6_intr", 32'(intr), 1);
    #2 clr = 1'b1; irq = '0;
    #1 chk("s6_async_intr", 32'(intr), 0); chk("s6_async_pend", 32'(pending), 0);
    chk("s6_async_cnt", 32'(ack_cnt), 0);
    step(); clr = 1'b0; step();

    // 256 acknowledges wrap the counter
    for (int i = 0; i < 256; i++) begin
      irq = 4'b0001; step(2);
      inta = 1'b1; irq = '0; step();
      inta = 1'b0; step();
      if (i == 254) chk("s6_cnt_255", 32'(ack_cnt), 255);
    end
    chk("s6_cnt_wrap", 32'(ack_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
